// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared constants, types and helpers for the fetch stage.
//
// Contents:
//   INST_W            instruction / address width (32)
//   RESET_PC_DEFAULT  default PC loaded on reset
//   NOP_INST_DEFAULT  default bubble instruction (ADD x0,x0,x0)
//   if_id_t           IF/ID pipeline register layout
//   pc_plus4()        sequential next PC, wraps modulo 2^32
//   align_target()    clears the two low bits of a redirect target
package fetch_pkg;

  localparam int unsigned INST_W = 32;

  localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0033;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] pc4;
    logic [INST_W-1:0] inst;
    logic              valid;
  } if_id_t;

  function automatic logic [INST_W-1:0] pc_plus4(input logic [INST_W-1:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [INST_W-1:0] align_target(input logic [INST_W-1:0] target);
    return {target[INST_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if -- groups the hazard/redirect controls, the shared memory
// read port and the IF/ID outputs of the fetch stage.
//
// Signals:
//   stall, redirect, redirect_pc  control from hazard unit / branch resolution
//   mem_rdata                     combinational read data of the shared memory
//   fetch_slot, fetch_addr        memory address mux select and fetch address
//   if_id_pc/pc4/inst/valid       IF/ID pipeline register
//   fetch_count                   only when FETCH_PERF_CNT_EN is defined
//
// Modports:
//   master  the fetch stage itself
//   slave   the surrounding pipeline / memory
interface fetch_stage_if;
  import fetch_pkg::*;

  logic              stall;
  logic              redirect;
  logic [INST_W-1:0] redirect_pc;
  logic [INST_W-1:0] mem_rdata;
  logic              fetch_slot;
  logic [INST_W-1:0] fetch_addr;
  logic [INST_W-1:0] if_id_pc;
  logic [INST_W-1:0] if_id_pc4;
  logic [INST_W-1:0] if_id_inst;
  logic              if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       fetch_count;
`endif

  modport master (
`ifdef FETCH_PERF_CNT_EN
    output fetch_count,
`endif
    input  stall, redirect, redirect_pc, mem_rdata,
    output fetch_slot, fetch_addr, if_id_pc, if_id_pc4, if_id_inst, if_id_valid
  );

  modport slave (
`ifdef FETCH_PERF_CNT_EN
    input  fetch_count,
`endif
    output stall, redirect, redirect_pc, mem_rdata,
    input  fetch_slot, fetch_addr, if_id_pc, if_id_pc4, if_id_inst, if_id_valid
  );

endinterface

// File: rtl/pc_register.sv
// pc_register -- program counter with synchronous reset and load enable.
//
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset, loads RESET_VAL
//   load   when high, q takes d on the next edge; otherwise q holds
//   d      next PC value
//   q      current PC value
module pc_register
  import fetch_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_VAL = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [INST_W-1:0] d,
  output logic [INST_W-1:0] q
);

  // NOTE: state is written with <= so every flop samples its inputs from
  // before the edge; a blocking = here would leak same-edge updates.
  always_ff @(posedge clk) begin
    if (rst)       q <= RESET_VAL;
    else if (load) q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch for a core sharing one single-port memory
// between instruction fetch and data access. The stage alternates a fetch
// slot and a data slot, so one instruction is issued every two cycles.
//
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset (overrides redirect and stall)
//   bus   fetch_stage_if.master: stall/redirect/redirect_pc/mem_rdata in,
//         fetch_slot/fetch_addr/IF-ID register (and fetch_count) out
//
// Optional feature: define FETCH_PERF_CNT_EN to add the 32-bit fetch_count
// output, counting every edge that loads a fetched instruction into IF/ID.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  fetch_stage_if.master  bus
);

  localparam logic [0:0] SLOT_DATA  = 1'b0;
  localparam logic [0:0] SLOT_FETCH = 1'b1;

  logic [0:0]        slot;
  logic [INST_W-1:0] pc;
  logic [INST_W-1:0] pc_next;
  logic              pc_load;
  logic              do_fetch;
  if_id_t            if_id;

  // A fetch completes only in the fetch slot, unstalled and not redirected.
  assign do_fetch = (slot == SLOT_FETCH) && !bus.stall && !bus.redirect;
  assign pc_load  = bus.redirect || do_fetch;

  // NOTE: the combinational block assigns pc_next on every path (default
  // first) so no latch is inferred.
  always_comb begin
    pc_next = pc_plus4(pc);
    if (bus.redirect) pc_next = align_target(bus.redirect_pc);
  end

  pc_register #(.RESET_VAL(RESET_PC)) u_pc (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .d    (pc_next),
    .q    (pc)
  );

  // Slot toggles unconditionally; stall and redirect never shift the phase.
  always_ff @(posedge clk) begin
    if (rst) slot <= SLOT_FETCH;
    else     slot <= ~slot;
  end

  // On a flush the PC fields are left alone; only inst/valid become a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id <= '{pc: '0, pc4: '0, inst: NOP_INST, valid: 1'b0};
    end else if (bus.redirect) begin
      if_id.inst  <= NOP_INST;
      if_id.valid <= 1'b0;
    end else if (do_fetch) begin
      if_id <= '{pc: pc, pc4: pc_plus4(pc), inst: bus.mem_rdata, valid: 1'b1};
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;

  always_ff @(posedge clk) begin
    if (rst)           fetch_count <= '0;
    else if (do_fetch) fetch_count <= fetch_count + 32'd1;
  end

  assign bus.fetch_count = fetch_count;
`endif

  assign bus.fetch_slot  = slot[0];
  assign bus.fetch_addr  = pc;
  assign bus.if_id_pc    = if_id.pc;
  assign bus.if_id_pc4   = if_id.pc4;
  assign bus.if_id_inst  = if_id.inst;
  assign bus.if_id_valid = if_id.valid;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The module SHALL have parameter NOP_INST, default 32'h0000_0033 (ADD x0,x0,x0), meaning the instruction word inserted into IF/ID on reset and flush.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The module SHALL have port stall, input, 1 bit: hazard unit requests that PC and IF/ID hold.
REQ-006 The module SHALL have port redirect, input, 1 bit: a taken branch or jump resolved downstream.
REQ-007 The module SHALL have port redirect_pc, input, 32 bits: the branch or jump target.
REQ-008 The module SHALL have port mem_rdata, input, 32 bits: combinational read data from the shared single-port memory.
REQ-009 The module SHALL have port fetch_slot, output, 1 bit: 1 = instruction slot; it drives the select of the downstream memory-address 2:1 mux (1 selects fetch_addr, 0 selects the data address).
REQ-010 The module SHALL have port fetch_addr, output, 32 bits: the current PC.
REQ-011 The module SHALL have ports if_id_pc and if_id_pc4 (outputs, 32 bits each), if_id_inst (output, 32 bits) and if_id_valid (output, 1 bit), forming the IF/ID pipeline register.

Function
REQ-012 fetch_slot SHALL toggle every cycle, independent of stall and redirect, so that one instruction is issued per two cycles.
REQ-013 fetch_addr SHALL equal the PC register combinationally, with zero latency.
REQ-014 On an edge with fetch_slot=1, redirect=0 and stall=0, the block SHALL set PC to PC+4 (modulo 2^32, wrapping 32'hFFFF_FFFC to 0) and load IF/ID with {PC, PC+4, mem_rdata, valid=1}.
REQ-015 On an edge with fetch_slot=1, stall=1 and redirect=0, PC and all IF/ID fields SHALL hold.
REQ-016 On an edge with fetch_slot=0 and redirect=0, PC and IF/ID SHALL hold; the data slot does not advance fetch.
REQ-017 On any edge with redirect=1, the block SHALL load PC with {redirect_pc[31:2],2'b00} and flush IF/ID to {if_id_inst=NOP_INST, if_id_valid=0}, regardless of slot.
REQ-018 redirect SHALL take priority over stall; on simultaneous assertion the redirect is taken and the stall is ignored for that edge.
REQ-019 During a flush, if_id_pc and if_id_pc4 SHALL hold their previous values; only if_id_inst and if_id_valid change.

Reset
REQ-020 With rst=1 at an edge, the block SHALL set PC=RESET_PC, fetch_slot=1, if_id_pc=0, if_id_pc4=0, if_id_inst=NOP_INST and if_id_valid=0.
REQ-021 rst SHALL override redirect and stall, and an instruction fetched in the same cycle as reset SHALL be discarded.
REQ-022 The first fetch after reset deassertion SHALL occur on the first edge with rst=0, at address RESET_PC.

Configuration
REQ-023 With macro FETCH_PERF_CNT_EN defined, the block SHALL add output fetch_count (32 bits): reset to 0, incremented by 1 on every edge performing a REQ-014 load, and wrapping at 2^32.
REQ-024 Without FETCH_PERF_CNT_EN defined, the fetch_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 The constants NOP_INST default, RESET_PC default and the instruction width (32) SHALL reside in the shared package fetch_pkg.
REQ-026 The PC SHALL be held in one sub-module, pc_register: 32 bits, with synchronous reset value, load enable and data input.
REQ-027 The slot toggle, the IF/ID register and the next-PC selection SHALL reside in fetch_stage itself.

Verification
REQ-028 Reset/run: assert rst for 2 cycles, then release with mem_rdata=32'h0000_0013 -> fetch_addr sequence 0,0,4,4,8; if_id_valid=1 from the first fetch edge; if_id_pc follows 0,4,8.
REQ-029 Stall: at PC=8 in the fetch slot, assert stall for 3 cycles -> PC stays 8 and IF/ID is unchanged; after release the next fetch-slot edge gives PC=12.
REQ-030 Redirect in the data slot: redirect=1, redirect_pc=32'h0000_0103 -> PC=32'h100, if_id_inst=32'h0000_0033, if_id_valid=0; the next fetch captures address 32'h100.
REQ-031 Simultaneous redirect+stall: redirect_pc=32'h40, stall=1 -> PC=32'h40 and IF/ID is flushed.
REQ-032 Wrap: redirect to 32'hFFFF_FFFC, then one fetch -> PC=0 and if_id_pc4=0.
REQ-033 With FETCH_PERF_CNT_EN: 10 fetches, 2 stalled fetch slots and 1 flush -> fetch_count=10; rst mid-run -> fetch_count=0.
